memory_burst_master: RTL and testbench
======================================

// Module: memory_burst_master
// PURPOSE
//  Initiator for the single-port word memory. Accepts burst commands (base address + length),
//  moves a write stream into memory or reads memory out as a stream, one word per access.
//  Sits between pipeline stages (valid/ready) and the memory's addr/read/write/data pins.
//  The memory samples on the falling edge; this block runs entirely on the rising edge.
// PARAMETERS
//  DATA_SIZE    14  word width, equal to the memory's data width
//  ADDR_SIZE    19  address width, equal to the memory's address width
//  MEMORY_SIZE  10  number of valid words; legal addresses are 0..MEMORY_SIZE-1
//  LEN_SIZE     8   burst length counter width
// PORTS
//  i_clock          in   1         rising-edge clock
//  i_reset          in   1         asynchronous, active-low reset
//  i_cmd_valid      in   1         command present
//  i_cmd_write      in   1         1 = write burst, 0 = read burst
//  i_cmd_addr       in   ADDR_SIZE burst base address
//  i_cmd_len        in   LEN_SIZE  number of words
//  o_cmd_ready      out  1         command accepted when valid&ready
//  i_wr_valid       in   1         write word present
//  i_wr_data        in   DATA_SIZE write word
//  o_wr_ready       out  1         write word accepted when valid&ready
//  o_rd_valid       out  1         read word present
//  o_rd_data        out  DATA_SIZE read word
//  i_rd_ready       in   1         downstream accepts read word
//  o_done           out  1         one-cycle pulse: burst finished
//  o_error          out  1         one-cycle pulse with o_done: command rejected
//  o_mem_addr       out  ADDR_SIZE to memory address
//  o_mem_read       out  1         to memory read strobe
//  o_mem_write      out  1         to memory write strobe
//  o_mem_data       out  DATA_SIZE to memory write data
//  i_mem_data       in   DATA_SIZE from memory read data
// BEHAVIOUR
//  - Reset (i_reset=0, async): state IDLE. All outputs 0, except o_cmd_ready=1.
//    An in-flight burst is abandoned. Words already written stay in memory.
//  - FSM: IDLE, WR, RD_ISSUE, RD_HOLD, DONE.
//    o_cmd_ready=1 only in IDLE. o_wr_ready=1 only in WR.
//  - IDLE, command accepted:
//    - i_cmd_addr>=MEMORY_SIZE -> DONE with o_error=1. No memory access.
//    - i_cmd_len==0 -> DONE, o_error=0. No memory access.
//    - Otherwise latch addr/len; go to WR (write) or RD_ISSUE (read).
//  - Address sequence is base, base+1, ...; after MEMORY_SIZE-1 it wraps to 0.
//    len>MEMORY_SIZE is legal and revisits addresses.
//  - Memory-side outputs are registered. o_mem_read and o_mem_write are never both 1.
//    Each strobe is high exactly one cycle per word.
//  - WR: each accepted beat drives o_mem_write=1, o_mem_addr=cur, o_mem_data=word
//    for the following cycle. Throughput 1 word/cycle.
//    After the last beat go to DONE; the last strobe is high during the DONE cycle.
//  - RD_ISSUE: o_mem_read=1 and o_mem_addr=cur for one cycle.
//    Next edge: capture i_mem_data into o_rd_data, set o_rd_valid=1, go to RD_HOLD.
//    Read latency is 1 cycle from strobe to o_rd_valid.
//  - RD_HOLD: o_rd_valid and o_rd_data are held stable until i_rd_ready=1.
//    On handshake, clear o_rd_valid; go to RD_ISSUE (words left) or DONE (last word).
//    Max rate is 1 word per 2 cycles.
//  - DONE: o_done=1 for one cycle, then IDLE. A new command can be accepted the next cycle.
//  - Inputs outside their handshake state are ignored (i_wr_valid in RD, i_cmd_valid mid-burst).
// TESTING
//  1. Write base=3 len=4, data 0x0A,0x0B,0x0C,0x0D streamed back-to-back
//     -> 4 consecutive o_mem_write cycles, addr 3..6; o_done on the cycle after the last beat.
//  2. Read base=3 len=4, i_rd_ready=1 -> o_rd_data 0x0A..0x0D;
//     o_rd_valid 1 cycle after each o_mem_read; o_done after word 4.
//  3. Write then read base=8 len=4 -> addresses 8,9,0,1 in order; data round-trips intact.
//  4. Read len=2 with i_rd_ready=0 for 5 cycles -> o_rd_valid and o_rd_data stable;
//     no second o_mem_read until the handshake.
//  5. Cmd len=0 -> o_done the next cycle, no strobe.
//     Cmd addr=12 -> o_done+o_error, no strobe.
//  6. i_reset=0 after 2 of 4 write beats -> all outputs 0 immediately, o_cmd_ready=1;
//     the next command runs normally.

Source files
------------

// File: rtl/memory_burst_master.sv
// memory_burst_master
//   Burst initiator for a single-port word memory. A command (base address +
//   length) either streams write words into memory or streams memory words out
//   as read data, one memory access per word. Addresses wrap from
//   MEMORY_SIZE-1 back to 0. All memory-side outputs are registered on the
//   rising edge; the memory itself samples on the falling edge.
// Ports
//   i_clock, i_reset                rising-edge clock, async active-low reset
//   i_cmd_valid/write/addr/len      burst command, taken when o_cmd_ready
//   o_cmd_ready                     high only while idle
//   i_wr_valid, i_wr_data           write stream, taken when o_wr_ready
//   o_wr_ready                      high only during a write burst
//   o_rd_valid, o_rd_data           read stream, held until i_rd_ready
//   i_rd_ready                      downstream accepts read word
//   o_done, o_error                 one-cycle end-of-burst pulse (+ reject flag)
//   o_mem_addr/read/write/data      to memory
//   i_mem_data                      from memory
module memory_burst_master #(
  parameter int unsigned DATA_SIZE   = 14,
  parameter int unsigned ADDR_SIZE   = 19,
  parameter int unsigned MEMORY_SIZE = 10,
  parameter int unsigned LEN_SIZE    = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic                 i_cmd_write,
  input  logic [ADDR_SIZE-1:0] i_cmd_addr,
  input  logic [LEN_SIZE-1:0]  i_cmd_len,
  output logic                 o_cmd_ready,
  input  logic                 i_wr_valid,
  input  logic [DATA_SIZE-1:0] i_wr_data,
  output logic                 o_wr_ready,
  output logic                 o_rd_valid,
  output logic [DATA_SIZE-1:0] o_rd_data,
  input  logic                 i_rd_ready,
  output logic                 o_done,
  output logic                 o_error,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic [DATA_SIZE-1:0] o_mem_data,
  input  logic [DATA_SIZE-1:0] i_mem_data
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_HOLD,
    DONE
  } state_t;

  localparam logic [ADDR_SIZE-1:0] MEM_LIMIT = ADDR_SIZE'(MEMORY_SIZE);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEMORY_SIZE - 1);

  state_t               state;
  logic [ADDR_SIZE-1:0] cur_addr;
  logic [ADDR_SIZE-1:0] next_addr;
  logic [LEN_SIZE-1:0]  len_left;
  logic                 last_word;

  always_comb begin
    next_addr = (cur_addr == LAST_ADDR) ? '0 : cur_addr + ADDR_SIZE'(1);
    last_word = (len_left == LEN_SIZE'(1));
  end

  assign o_cmd_ready = (state == IDLE);
  assign o_wr_ready  = (state == WR);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      cur_addr    <= '0;
      len_left    <= '0;
      o_mem_addr  <= '0;
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
      o_mem_data  <= '0;
      o_rd_valid  <= 1'b0;
      o_rd_data   <= '0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      // Strobes and status pulses last one cycle unless re-asserted below.
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            if (i_cmd_addr >= MEM_LIMIT) begin
              state   <= DONE;
              o_done  <= 1'b1;
              o_error <= 1'b1;
            end else if (i_cmd_len == '0) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              cur_addr <= i_cmd_addr;
              len_left <= i_cmd_len;
              if (i_cmd_write) begin
                state <= WR;
              end else begin
                // Read strobe is registered here so it is high during RD_ISSUE.
                state      <= RD_ISSUE;
                o_mem_read <= 1'b1;
                o_mem_addr <= i_cmd_addr;
              end
            end
          end
        end
        WR: begin
          if (i_wr_valid) begin
            o_mem_write <= 1'b1;
            o_mem_addr  <= cur_addr;
            o_mem_data  <= i_wr_data;
            if (last_word) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              cur_addr <= next_addr;
              len_left <= len_left - LEN_SIZE'(1);
            end
          end
        end
        RD_ISSUE: begin
          o_rd_data  <= i_mem_data;
          o_rd_valid <= 1'b1;
          state      <= RD_HOLD;
        end
        RD_HOLD: begin
          if (i_rd_ready) begin
            o_rd_valid <= 1'b0;
            if (last_word) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              cur_addr   <= next_addr;
              len_left   <= len_left - LEN_SIZE'(1);
              state      <= RD_ISSUE;
              o_mem_read <= 1'b1;
              o_mem_addr <= next_addr;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_burst_master.sv
// tb_memory_burst_master
//   Drives memory_burst_master against a behavioural falling-edge memory and
//   checks strobes, address sequences, read data and status pulses against a
//   reference memory image computed with modulo address arithmetic.
module tb_memory_burst_master;

  localparam int M = 10;

  logic        clk;
  logic        i_reset;
  logic        i_cmd_valid;
  logic        i_cmd_write;
  logic [18:0] i_cmd_addr;
  logic [7:0]  i_cmd_len;
  logic        o_cmd_ready;
  logic        i_wr_valid;
  logic [13:0] i_wr_data;
  logic        o_wr_ready;
  logic        o_rd_valid;
  logic [13:0] o_rd_data;
  logic        i_rd_ready;
  logic        o_done;
  logic        o_error;
  logic [18:0] o_mem_addr;
  logic        o_mem_read;
  logic        o_mem_write;
  logic [13:0] o_mem_data;
  logic [13:0] i_mem_data;

  memory_burst_master #(
    .DATA_SIZE  (14),
    .ADDR_SIZE  (19),
    .MEMORY_SIZE(10),
    .LEN_SIZE   (8)
  ) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_cmd_valid(i_cmd_valid),
    .i_cmd_write(i_cmd_write),
    .i_cmd_addr (i_cmd_addr),
    .i_cmd_len  (i_cmd_len),
    .o_cmd_ready(o_cmd_ready),
    .i_wr_valid (i_wr_valid),
    .i_wr_data  (i_wr_data),
    .o_wr_ready (o_wr_ready),
    .o_rd_valid (o_rd_valid),
    .o_rd_data  (o_rd_data),
    .i_rd_ready (i_rd_ready),
    .o_done     (o_done),
    .o_error    (o_error),
    .o_mem_addr (o_mem_addr),
    .o_mem_read (o_mem_read),
    .o_mem_write(o_mem_write),
    .o_mem_data (o_mem_data),
    .i_mem_data (i_mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  // Reference image of memory contents and the memory model itself.
  logic [13:0] ref_mem [M];
  logic [13:0] mem [M];
  logic [13:0] mem_rdata;
  logic        mem_fill;
  assign i_mem_data = mem_rdata;

  // Observed strobes and pulses.
  logic [18:0] mon_wa_q [$];
  logic [13:0] mon_wd_q [$];
  logic [18:0] mon_ra_q [$];
  logic [13:0] got_rd_q [$];
  logic [13:0] wdata_q  [$];
  int          done_cnt;
  int          err_cnt;
  bit          both_seen;

  always @(negedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < M; i++) mem[i] <= ref_mem[i];
    end else begin
      if (o_mem_write) begin
        if (o_mem_addr < 19'(M)) mem[o_mem_addr[3:0]] <= o_mem_data;
        mon_wa_q.push_back(o_mem_addr);
        mon_wd_q.push_back(o_mem_data);
      end
      if (o_mem_read) begin
        if (o_mem_addr < 19'(M)) mem_rdata <= mem[o_mem_addr[3:0]];
        mon_ra_q.push_back(o_mem_addr);
      end
      if (o_mem_read && o_mem_write) both_seen = 1'b1;
      if (o_done) done_cnt++;
      if (o_error) err_cnt++;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    mon_wa_q.delete();
    mon_wd_q.delete();
    mon_ra_q.delete();
    got_rd_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // Stimulus only: issues one command and services its data handshakes.
  task automatic run_burst(input bit wr, input int base, input int len, input bit jitter);
    int budget;
    int beats;
    bit acc;
    bit hs;
    budget = 400;
    while (!o_cmd_ready && budget > 0) begin step; budget--; end
    clear_mon();
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = 19'(base);
    i_cmd_len   = 8'(len);
    step;
    i_cmd_valid = 1'b0;
    i_cmd_addr  = 19'($urandom);
    i_cmd_len   = 8'($urandom);
    if (base < M && len > 0) begin
      if (wr) begin
        beats = 0;
        while (beats < len && budget > 0) begin
          i_wr_valid  = jitter ? ($urandom_range(0, 3) != 0) : 1'b1;
          i_wr_data   = wdata_q[beats];
          i_cmd_valid = !o_cmd_ready && jitter && ($urandom_range(0, 1) == 1);
          acc = i_wr_valid && o_wr_ready;
          step;
          budget--;
          if (acc) beats++;
        end
      end else begin
        while (got_rd_q.size() < len && budget > 0) begin
          i_rd_ready  = jitter ? ($urandom_range(0, 2) != 0) : 1'b1;
          i_wr_valid  = jitter && ($urandom_range(0, 1) == 1);
          i_wr_data   = 14'($urandom);
          i_cmd_valid = !o_cmd_ready && jitter && ($urandom_range(0, 1) == 1);
          hs = o_rd_valid && i_rd_ready;
          if (hs) got_rd_q.push_back(o_rd_data);
          step;
          budget--;
        end
      end
    end
    i_wr_valid  = 1'b0;
    i_rd_ready  = 1'b0;
    i_cmd_valid = 1'b0;
    while (done_cnt == 0 && budget > 0) begin step; budget--; end
    step;
    if (budget <= 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL burst_timeout: wr=%0d base=%0d len=%0d got done_cnt=%0d, need 1", wr, base, len, done_cnt);
    end
  endtask

  task automatic test_reset;
    tests_run++;
    if ({o_cmd_ready, o_wr_ready, o_rd_valid, o_done, o_error, o_mem_read, o_mem_write} !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b need 1000000",
               {o_cmd_ready, o_wr_ready, o_rd_valid, o_done, o_error, o_mem_read, o_mem_write});
    end
    tests_run++;
    if (o_rd_data !== 14'd0 || o_mem_addr !== 19'd0 || o_mem_data !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_data: rd_data=%h mem_addr=%h mem_data=%h need all 0", o_rd_data, o_mem_addr, o_mem_data);
    end
    @(negedge clk);
    #1 i_reset = 1'b1;
    step;
  endtask

  task automatic test_write_basic;
    logic [13:0] vals [4];
    vals = '{14'h0A, 14'h0B, 14'h0C, 14'h0D};
    clear_mon();
    i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 19'd3; i_cmd_len = 8'd4;
    step;
    i_cmd_valid = 1'b0;
    tests_run++;
    if (o_wr_ready !== 1'b1 || o_cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_enter: wr_ready=%b cmd_ready=%b need 1 0", o_wr_ready, o_cmd_ready);
    end
    for (int k = 0; k < 4; k++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = vals[k];
      step;
      tests_run++;
      if (o_mem_write !== 1'b1 || o_mem_read !== 1'b0 || o_mem_addr !== 19'(3 + k) ||
          o_mem_data !== vals[k] || o_done !== (k == 3)) begin
        tests_failed++;
        $display("FAIL wr_beat%0d: write=%b read=%b addr=%0d data=%h done=%b need 1 0 %0d %h %b",
                 k, o_mem_write, o_mem_read, o_mem_addr, o_mem_data, o_done, 3 + k, vals[k], (k == 3));
      end
    end
    i_wr_valid = 1'b0;
    step;
    tests_run++;
    if (o_done !== 1'b0 || o_mem_write !== 1'b0 || o_cmd_ready !== 1'b1 || mon_wa_q.size() != 4) begin
      tests_failed++;
      $display("FAIL wr_end: done=%b write=%b cmd_ready=%b strobes=%0d need 0 0 1 4",
               o_done, o_mem_write, o_cmd_ready, mon_wa_q.size());
    end
    for (int k = 0; k < 4; k++) ref_mem[3 + k] = vals[k];
  endtask

  task automatic test_read_basic;
    logic [13:0] vals [4];
    vals = '{14'h0A, 14'h0B, 14'h0C, 14'h0D};
    clear_mon();
    i_rd_ready  = 1'b1;
    i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 19'd3; i_cmd_len = 8'd4;
    step;
    i_cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (o_mem_read !== 1'b1 || o_mem_write !== 1'b0 || o_mem_addr !== 19'(3 + k) || o_rd_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rd_issue%0d: read=%b write=%b addr=%0d rd_valid=%b need 1 0 %0d 0",
                 k, o_mem_read, o_mem_write, o_mem_addr, o_rd_valid, 3 + k);
      end
      step;
      tests_run++;
      if (o_rd_valid !== 1'b1 || o_rd_data !== vals[k] || o_mem_read !== 1'b0) begin
        tests_failed++;
        $display("FAIL rd_data%0d: rd_valid=%b data=%h read=%b need 1 %h 0",
                 k, o_rd_valid, o_rd_data, o_mem_read, vals[k]);
      end
      step;
    end
    tests_run++;
    if (o_done !== 1'b1 || o_error !== 1'b0 || o_rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_done: done=%b error=%b rd_valid=%b need 1 0 0", o_done, o_error, o_rd_valid);
    end
    i_rd_ready = 1'b0;
    step;
    tests_run++;
    if (o_done !== 1'b0 || o_cmd_ready !== 1'b1 || mon_ra_q.size() != 4) begin
      tests_failed++;
      $display("FAIL rd_end: done=%b cmd_ready=%b reads=%0d need 0 1 4", o_done, o_cmd_ready, mon_ra_q.size());
    end
  endtask

  task automatic test_wrap;
    bit bad;
    wdata_q.delete();
    for (int i = 0; i < 4; i++) wdata_q.push_back(14'($urandom));
    run_burst(1'b1, 8, 4, 1'b1);
    bad = (mon_wa_q.size() != 4) || (done_cnt != 1);
    for (int i = 0; i < mon_wa_q.size() && i < 4; i++)
      if (mon_wa_q[i] !== 19'((8 + i) % M) || mon_wd_q[i] !== wdata_q[i]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL wrap_write: strobes=%0d done=%0d first_addr=%0d need 4 1 8 (seq 8,9,0,1)",
               mon_wa_q.size(), done_cnt, (mon_wa_q.size() > 0) ? int'(mon_wa_q[0]) : -1);
    end
    for (int i = 0; i < 4; i++) ref_mem[(8 + i) % M] = wdata_q[i];
    run_burst(1'b0, 8, 4, 1'b1);
    bad = (mon_ra_q.size() != 4) || (got_rd_q.size() != 4) || (done_cnt != 1);
    for (int i = 0; i < mon_ra_q.size() && i < 4; i++)
      if (mon_ra_q[i] !== 19'((8 + i) % M)) bad = 1'b1;
    for (int i = 0; i < got_rd_q.size() && i < 4; i++)
      if (got_rd_q[i] !== wdata_q[i]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL wrap_read: reads=%0d words=%0d done=%0d first=%h need 4 4 1 %h",
               mon_ra_q.size(), got_rd_q.size(), done_cnt,
               (got_rd_q.size() > 0) ? got_rd_q[0] : 14'h0, wdata_q[0]);
    end
  endtask

  task automatic test_backpressure;
    clear_mon();
    i_rd_ready  = 1'b0;
    i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 19'd5; i_cmd_len = 8'd2;
    step;
    i_cmd_valid = 1'b0;
    step;
    for (int c = 0; c < 5; c++) begin
      step;
      tests_run++;
      if (o_rd_valid !== 1'b1 || o_rd_data !== ref_mem[5] || o_mem_read !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: rd_valid=%b data=%h read=%b need 1 %h 0",
                 c, o_rd_valid, o_rd_data, o_mem_read, ref_mem[5]);
      end
    end
    tests_run++;
    if (mon_ra_q.size() != 1) begin
      tests_failed++;
      $display("FAIL bp_reads: reads=%0d need 1", mon_ra_q.size());
    end
    i_rd_ready = 1'b1;
    step;
    tests_run++;
    if (o_rd_valid !== 1'b0 || o_mem_read !== 1'b1 || o_mem_addr !== 19'd6) begin
      tests_failed++;
      $display("FAIL bp_next: rd_valid=%b read=%b addr=%0d need 0 1 6", o_rd_valid, o_mem_read, o_mem_addr);
    end
    i_rd_ready = 1'b0;
    step;
    tests_run++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== ref_mem[6]) begin
      tests_failed++;
      $display("FAIL bp_word2: rd_valid=%b data=%h need 1 %h", o_rd_valid, o_rd_data, ref_mem[6]);
    end
    i_rd_ready = 1'b1;
    step;
    tests_run++;
    if (o_done !== 1'b1 || o_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_done: done=%b error=%b need 1 0", o_done, o_error);
    end
    i_rd_ready = 1'b0;
    step;
  endtask

  task automatic test_zero_len_error;
    clear_mon();
    i_wr_valid  = 1'b1;
    i_wr_data   = 14'h1234;
    i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 19'd2; i_cmd_len = 8'd0;
    step;
    i_cmd_valid = 1'b0;
    tests_run++;
    if (o_done !== 1'b1 || o_error !== 1'b0 || o_wr_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL len0_done: done=%b error=%b wr_ready=%b need 1 0 0", o_done, o_error, o_wr_ready);
    end
    step;
    tests_run++;
    if (o_done !== 1'b0 || o_cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL len0_idle: done=%b cmd_ready=%b need 0 1", o_done, o_cmd_ready);
    end
    for (int j = 0; j < 2; j++) begin
      i_cmd_valid = 1'b1;
      i_cmd_write = (j == 1);
      i_cmd_addr  = (j == 0) ? 19'd12 : 19'd10;
      i_cmd_len   = 8'd3;
      step;
      i_cmd_valid = 1'b0;
      tests_run++;
      if (o_done !== 1'b1 || o_error !== 1'b1 || o_wr_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bad_addr%0d: done=%b error=%b wr_ready=%b need 1 1 0", j, o_done, o_error, o_wr_ready);
      end
      step;
      tests_run++;
      if (o_done !== 1'b0 || o_error !== 1'b0 || o_cmd_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL bad_addr_idle%0d: done=%b error=%b cmd_ready=%b need 0 0 1", j, o_done, o_error, o_cmd_ready);
      end
    end
    i_wr_valid = 1'b0;
    tests_run++;
    if (mon_wa_q.size() != 0 || mon_ra_q.size() != 0) begin
      tests_failed++;
      $display("FAIL noaccess: writes=%0d reads=%0d need 0 0", mon_wa_q.size(), mon_ra_q.size());
    end
  endtask

  task automatic test_reset_midburst;
    logic [13:0] d [4];
    bit bad;
    for (int i = 0; i < 4; i++) d[i] = 14'($urandom);
    i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 19'd4; i_cmd_len = 8'd4;
    step;
    i_cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = d[k];
      if (k < 2) step;
    end
    @(negedge clk);
    #1 i_reset = 1'b0;
    #1;
    tests_run++;
    if ({o_cmd_ready, o_wr_ready, o_rd_valid, o_done, o_error, o_mem_read, o_mem_write} !== 7'b1000000 ||
        o_mem_addr !== 19'd0 || o_mem_data !== 14'd0 || o_rd_data !== 14'd0) begin
      tests_failed++;
      $display("FAIL midreset: ctrl=%b addr=%0d data=%h rd=%h need 1000000 0 0 0",
               {o_cmd_ready, o_wr_ready, o_rd_valid, o_done, o_error, o_mem_read, o_mem_write},
               o_mem_addr, o_mem_data, o_rd_data);
    end
    i_wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 i_reset = 1'b1;
    step;
    ref_mem[4] = d[0];
    ref_mem[5] = d[1];
    run_burst(1'b0, 4, 4, 1'b0);
    bad = (got_rd_q.size() != 4) || (done_cnt != 1) || (err_cnt != 0);
    for (int i = 0; i < got_rd_q.size() && i < 4; i++)
      if (got_rd_q[i] !== ref_mem[4 + i]) bad = 1'b1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL after_reset_read: words=%0d done=%0d w0=%h w2=%h need 4 1 %h %h",
               got_rd_q.size(), done_cnt, (got_rd_q.size() > 0) ? got_rd_q[0] : 14'h0,
               (got_rd_q.size() > 2) ? got_rd_q[2] : 14'h0, ref_mem[4], ref_mem[6]);
    end
  endtask

  task automatic test_random;
    bit wr;
    int base;
    int len;
    bit exp_err;
    bit active;
    bit bad;
    for (int n = 0; n < 24; n++) begin
      wr      = ($urandom_range(0, 1) == 1);
      base    = $urandom_range(0, 12);
      len     = $urandom_range(0, 13);
      exp_err = (base >= M);
      active  = !exp_err && (len > 0);
      wdata_q.delete();
      for (int i = 0; i < len; i++) wdata_q.push_back(14'($urandom));
      run_burst(wr, base, len, 1'b1);
      tests_run++;
      if (done_cnt != 1 || err_cnt != int'(exp_err)) begin
        tests_failed++;
        $display("FAIL rand%0d_status: done=%0d error=%0d need 1 %0d (base=%0d len=%0d)",
                 n, done_cnt, err_cnt, exp_err, base, len);
      end
      bad = 1'b0;
      if (wr) begin
        if (mon_wa_q.size() != (active ? len : 0) || mon_ra_q.size() != 0) bad = 1'b1;
        for (int i = 0; i < mon_wa_q.size() && i < len; i++)
          if (mon_wa_q[i] !== 19'((base + i) % M) || mon_wd_q[i] !== wdata_q[i]) bad = 1'b1;
        if (active) for (int i = 0; i < len; i++) ref_mem[(base + i) % M] = wdata_q[i];
      end else begin
        if (mon_ra_q.size() != (active ? len : 0) || mon_wa_q.size() != 0 ||
            got_rd_q.size() != (active ? len : 0)) bad = 1'b1;
        for (int i = 0; i < mon_ra_q.size() && i < len; i++)
          if (mon_ra_q[i] !== 19'((base + i) % M)) bad = 1'b1;
        for (int i = 0; i < got_rd_q.size() && i < len; i++)
          if (got_rd_q[i] !== ref_mem[(base + i) % M]) bad = 1'b1;
      end
      tests_run++;
      if (bad) begin
        tests_failed++;
        $display("FAIL rand%0d_stream: wr=%0d base=%0d len=%0d writes=%0d reads=%0d words=%0d need %0d accesses",
                 n, wr, base, len, mon_wa_q.size(), mon_ra_q.size(), got_rd_q.size(), active ? len : 0);
      end
    end
    tests_run++;
    if (both_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL strobe_exclusive: both strobes seen=%b need 0", both_seen);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    both_seen    = 1'b0;
    done_cnt     = 0;
    err_cnt      = 0;
    mem_rdata    = '0;
    i_reset      = 1'b0;
    i_cmd_valid  = 1'b0;
    i_cmd_write  = 1'b0;
    i_cmd_addr   = '0;
    i_cmd_len    = '0;
    i_wr_valid   = 1'b0;
    i_wr_data    = '0;
    i_rd_ready   = 1'b0;
    for (int i = 0; i < M; i++) ref_mem[i] = 14'($urandom);
    mem_fill = 1'b1;
    @(negedge clk);
    #1 mem_fill = 1'b0;

    test_reset();
    test_write_basic();
    test_read_basic();
    test_wrap();
    test_backpressure();
    test_zero_len_error();
    test_reset_midburst();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
